// File: rtl/zimbo_control.sv
// zimbo_control: multi-cycle control FSM for the Zimbo 16-bit core.
// Decodes opcode/func/zero from the datapath into steering selects and
// PC / register-file / memory strobes. Handles the memory-ready handshake,
// the two-cycle multiply writeback and the halt state.
// Optional feature: define ZIMBO_PERF_CNT_EN to build the 16-bit
// retired-instruction counter; otherwise `retired` is tied to zero.
module zimbo_control #(
    parameter logic [4:0] HALT_OP = 5'b11111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  opcode,
    input  logic [2:0]  func,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_alu,
    output logic [1:0]  addrbase,
    output logic        mulreg,
    output logic        insdat,
    output logic        alusrc,
    output logic [2:0]  aluop,
    output logic        pcwrite,
    output logic [1:0]  pcsrc,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        illegal,
    output logic        halted,
    output logic [15:0] retired
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00001;
    localparam logic [4:0] OP_LW    = 5'b00010;
    localparam logic [4:0] OP_SW    = 5'b00011;
    localparam logic [4:0] OP_BEQ   = 5'b00100;
    localparam logic [4:0] OP_BNE   = 5'b00101;
    localparam logic [4:0] OP_J     = 5'b00110;
    localparam logic [4:0] OP_MUL   = 5'b00111;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_MUL  = 3'd7;

    typedef enum logic [2:0] {
        S_EXEC  = 3'd0,
        S_MEM   = 3'd1,
        S_MULHI = 3'd2,
        S_HALT  = 3'd3
    } state_t;

    state_t state_q, state_d;

    // Raw strobes before the reset override.
    logic pc_wr, reg_wr, mem_rd, mem_wr, ill;

    // Next-state and output decode from the current state and datapath fields.
    always_comb begin
        state_d  = state_q;
        mem_alu  = 1'b0;
        addrbase = 2'd1;
        mulreg   = 1'b0;
        insdat   = 1'b0;
        alusrc   = 1'b1;
        aluop    = ALU_ADD;
        pcsrc    = 2'd0;
        halted   = 1'b0;
        pc_wr    = 1'b0;
        reg_wr   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        ill      = 1'b0;

        case (state_q)
            S_EXEC: begin
                mem_rd = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        aluop  = func;
                        reg_wr = 1'b1;
                        pc_wr  = 1'b1;
                    end
                    OP_ADDI: begin
                        alusrc = 1'b0;
                        reg_wr = 1'b1;
                        pc_wr  = 1'b1;
                    end
                    OP_LW, OP_SW: begin
                        alusrc  = 1'b0;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        aluop    = ALU_SUB;
                        addrbase = 2'd2;
                        pc_wr    = 1'b1;
                        pcsrc    = zero ? 2'd1 : 2'd0;
                    end
                    OP_BNE: begin
                        aluop    = ALU_SUB;
                        addrbase = 2'd2;
                        pc_wr    = 1'b1;
                        pcsrc    = zero ? 2'd0 : 2'd1;
                    end
                    OP_J: begin
                        addrbase = 2'd0;
                        pc_wr    = 1'b1;
                        pcsrc    = 2'd2;
                    end
                    OP_MUL: begin
                        aluop   = ALU_MUL;
                        reg_wr  = 1'b1;
                        state_d = S_MULHI;
                    end
                    default: begin
                        if (opcode == HALT_OP) begin
                            state_d = S_HALT;
                        end else begin
                            // Undefined opcode: flag it and step over it as a NOP.
                            ill   = 1'b1;
                            pc_wr = 1'b1;
                        end
                    end
                endcase
                // Instruction fetch not complete yet: keep steering, suppress
                // every strobe and wait here.
                if (!mem_ready) begin
                    pc_wr   = 1'b0;
                    reg_wr  = 1'b0;
                    ill     = 1'b0;
                    state_d = S_EXEC;
                end
            end

            S_MEM: begin
                insdat  = 1'b1;
                mem_alu = 1'b1;
                alusrc  = 1'b0;
                if (opcode == OP_LW) begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        reg_wr  = 1'b1;
                        pc_wr   = 1'b1;
                        state_d = S_EXEC;
                    end
                end else if (opcode == OP_SW) begin
                    if (mem_ready) begin
                        mem_wr  = 1'b1;
                        pc_wr   = 1'b1;
                        state_d = S_EXEC;
                    end
                end else begin
                    // Opcode changed under us: abandon the access quietly.
                    state_d = S_EXEC;
                end
            end

            S_MULHI: begin
                aluop   = ALU_MUL;
                mulreg  = 1'b1;
                reg_wr  = 1'b1;
                pc_wr   = 1'b1;
                state_d = S_EXEC;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_EXEC;
            end
        endcase
    end

    // Strobes are held low for as long as reset is asserted.
    assign pcwrite  = pc_wr  & ~reset;
    assign regwrite = reg_wr & ~reset;
    assign memread  = mem_rd & ~reset;
    assign memwrite = mem_wr & ~reset;
    assign illegal  = ill    & ~reset;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_EXEC;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ZIMBO_PERF_CNT_EN
    logic [15:0] retired_q;

    // Count every PC update plus the step into halt; wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q <= 16'h0000;
        end else if (pcwrite || (state_d == S_HALT && state_q != S_HALT)) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign retired = retired_q;
`else
    assign retired = 16'h0000;
`endif

endmodule

// File: doc/zimbo_control.md
# zimbo_control

- Multi-cycle control FSM for the Zimbo 16-bit core. Sits directly upstream of the datapath.
- Consumes the `opcode`, `func` and ALU `zero` that the datapath decodes from the current instruction word.
- Drives every datapath steering select (`mem_alu`, `addrbase`, `mulreg`, `insdat`, `alusrc`) plus PC, register-file and memory write strobes.
- Owns the memory-ready handshake, the two-cycle multiply writeback and the halt state.

## Interface
Parameters:
- `HALT_OP`, 5'b11111: opcode that enters S_HALT.

Ports (clock and reset first):
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  5  instruction opcode from datapath.
- `func`  in  3  R-type function field.
- `zero`  in  1  ALU result == 0.
- `mem_ready`  in  1  memory access completes this cycle.
- `mem_alu`  out  1  1: instruction comes from latch, writeback data comes from memory.
- `addrbase`  out  2  source-register address select.
- `mulreg`  out  1  register-pair low bit; high half of multiply.
- `insdat`  out  1  memory address: 0 = PC, 1 = ALU result.
- `alusrc`  out  1  ALU B operand: 1 = rdata2, 0 = extended immediate.
- `aluop`  out  3  ALU operation.
- `pcwrite`  out  1  PC load strobe.
- `pcsrc`  out  2  PC source: 0 = pcin, 1 = pcbranch, 2 = pcjump.
- `regwrite`  out  1  register-file write strobe.
- `memread`  out  1  memory read request.
- `memwrite`  out  1  memory write strobe.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.
- `halted`  out  1  core is in S_HALT.
- `retired`  out  16  retired-instruction count.

## Operation
Opcode map (all other values are illegal):
- 00000: R-type.
- 00001: ADDI.
- 00010: LW.
- 00011: SW.
- 00100: BEQ.
- 00101: BNE.
- 00110: J.
- 00111: MUL.
- HALT_OP: halt.

States (3-bit encoding): S_EXEC=0, S_MEM=1, S_MULHI=2, S_HALT=3.

Default outputs are all zero, except `addrbase`=1 and `alusrc`=1.

S_EXEC: `insdat`=0, `mem_alu`=0, `memread`=1. With `mem_ready`=0, all strobes stay 0 and the state holds.
- R-type: `aluop`=`func`, `regwrite`=1, `pcwrite`=1, `pcsrc`=0.
- ADDI: `aluop`=0, `alusrc`=0, `regwrite`=1, `pcwrite`=1, `pcsrc`=0.
- LW/SW: `aluop`=0, `alusrc`=0. No strobes. Next state S_MEM.
- BEQ/BNE: `aluop`=1 (subtract), `addrbase`=2, `pcwrite`=1. `pcsrc`=1 if (`zero` for BEQ, ~`zero` for BNE), else 0.
- J: `addrbase`=0, `pcwrite`=1, `pcsrc`=2.
- MUL: `aluop`=7, `mulreg`=0, `regwrite`=1. No `pcwrite`. Next state S_MULHI.
- HALT_OP: no strobes. Next state S_HALT.
- Illegal: `illegal`=1, `pcwrite`=1, `pcsrc`=0. Executes as a NOP.

S_MEM: `insdat`=1, `mem_alu`=1, `aluop`=0, `alusrc`=0.
- LW: `memread`=1. When `mem_ready`=1: `regwrite`=1, `pcwrite`=1, `pcsrc`=0, next state S_EXEC.
- SW: when `mem_ready`=1: `memwrite`=1, `pcwrite`=1, `pcsrc`=0, next state S_EXEC.
- With `mem_ready`=0, the state holds with no strobes.

S_MULHI: `insdat`=0, `mem_alu`=0, `aluop`=7, `mulreg`=1, `regwrite`=1, `pcwrite`=1, `pcsrc`=0. Next state S_EXEC unconditionally.

S_HALT: `halted`=1, all strobes 0. Exited only by `reset`.

## Timing
- All outputs are combinational from the state register plus `opcode`, `func`, `zero` and `mem_ready`. There are no output registers except `retired`.
- Per-instruction latency in cycles, with zero wait states:
  - 1 for R-type, ADDI, branches, J and illegal.
  - 2 for LW, SW and MUL.
  - Each `mem_ready`=0 cycle adds one cycle in S_EXEC or S_MEM.
- Reset is asynchronous: state goes to S_EXEC immediately and `retired` clears to 0.
- While `reset`=1, `pcwrite`, `regwrite`, `memwrite`, `memread` and `illegal` are forced to 0.
- Reset asserted in S_MEM or S_MULHI abandons the instruction. No partial writes occur after the reset edge.
- A `mem_ready` drop in S_MEM stretches the access. The strobes fire in exactly one cycle, the one where `mem_ready`=1.
- `zero` is sampled only in the S_EXEC branch cycle.

## Configuration
- `ZIMBO_PERF_CNT_EN` defined:
  - `retired` is a 16-bit counter, wrapping 0xFFFF → 0x0000.
  - It increments on every clock edge where `pcwrite`=1, and on the edge entering S_HALT.
  - Illegal-opcode NOPs count.
- `ZIMBO_PERF_CNT_EN` undefined: `retired` is tied to 16'h0000 and no counter flops are inferred.

## Test plan
- Reset mid-S_MEM during an SW with `mem_ready`=0: next state S_EXEC, `memwrite` never pulses, `retired`=0.
- R-type `func`=3, `mem_ready`=1: one cycle with `aluop`=3, `regwrite`=1, `pcwrite`=1, `pcsrc`=0; stays in S_EXEC.
- LW with `mem_ready` low for 2 cycles in S_MEM: S_EXEC(1) → S_MEM held 2 cycles → S_MEM with `regwrite`=1, `mem_alu`=1, `insdat`=1 → S_EXEC. Total 4 cycles, one `regwrite` pulse.
- BEQ: with `zero`=1, `pcsrc`=1; with `zero`=0, `pcsrc`=0. BNE inverts both cases. `pcwrite`=1 in all four cases.
- MUL: cycle 1 `mulreg`=0, `regwrite`=1, `pcwrite`=0; cycle 2 `mulreg`=1, `regwrite`=1, `pcwrite`=1.
- Opcode 5'b01010, then HALT_OP: `illegal` pulses once, then `halted`=1 held indefinitely. With `ZIMBO_PERF_CNT_EN`, `retired`=2. Also force `retired` past 0xFFFF and confirm it wraps to 0.
